// File: rtl/key_pkg.sv
// Shared constants for the PS/2 key event controller: scan codes,
// key index order, one-hot key masks and parser state encodings.
package key_pkg;

  localparam int NUM_KEYS = 6;

  localparam logic [7:0] CODE_E0    = 8'hE0;
  localparam logic [7:0] CODE_F0    = 8'hF0;
  localparam logic [7:0] CODE_UP    = 8'h75;
  localparam logic [7:0] CODE_DOWN  = 8'h72;
  localparam logic [7:0] CODE_LEFT  = 8'h6B;
  localparam logic [7:0] CODE_RIGHT = 8'h74;
  localparam logic [7:0] CODE_ENTER = 8'h5A;
  localparam logic [7:0] CODE_ESC   = 8'h76;

  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;
  localparam int KEY_ENTER = 4;
  localparam int KEY_ESC   = 5;

  localparam logic [NUM_KEYS-1:0] KEY_UP_OH    = NUM_KEYS'(1) << KEY_UP;
  localparam logic [NUM_KEYS-1:0] KEY_DOWN_OH  = NUM_KEYS'(1) << KEY_DOWN;
  localparam logic [NUM_KEYS-1:0] KEY_LEFT_OH  = NUM_KEYS'(1) << KEY_LEFT;
  localparam logic [NUM_KEYS-1:0] KEY_RIGHT_OH = NUM_KEYS'(1) << KEY_RIGHT;
  localparam logic [NUM_KEYS-1:0] KEY_ENTER_OH = NUM_KEYS'(1) << KEY_ENTER;
  localparam logic [NUM_KEYS-1:0] KEY_ESC_OH   = NUM_KEYS'(1) << KEY_ESC;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  // Same mapping with or without the E0 prefix, so keypad keys alias in.
  function automatic logic [NUM_KEYS-1:0] decode_key(input logic [7:0] code);
    logic [NUM_KEYS-1:0] oh;
    oh = '0;
    case (code)
      CODE_UP:    oh = KEY_UP_OH;
      CODE_DOWN:  oh = KEY_DOWN_OH;
      CODE_LEFT:  oh = KEY_LEFT_OH;
      CODE_RIGHT: oh = KEY_RIGHT_OH;
      CODE_ENTER: oh = KEY_ENTER_OH;
      CODE_ESC:   oh = KEY_ESC_OH;
      default:    oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/key_repeat_timer.sv
// Auto-repeat down-counter for the most recently pressed repeatable key;
// expire is asserted combinationally in the cycle the count reaches zero.
module key_repeat_timer
  import key_pkg::*;
#(
  parameter int REPEAT_DELAY  = 32_500_000,
  parameter int REPEAT_PERIOD = 6_500_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arm,
  input  logic                disarm,
  input  logic [NUM_KEYS-1:0] arm_key,
  output logic                armed,
  output logic [NUM_KEYS-1:0] key,
  output logic                expire
);

  localparam int MAX_LOAD = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW       = $clog2(MAX_LOAD) + 1;

  logic [CW-1:0] count;

  // A fresh arm or a release in the same cycle suppresses the expiry.
  assign expire = armed && (count == '0) && !arm && !disarm;

  always_ff @(posedge clk) begin
    if (rst) begin
      armed <= 1'b0;
      key   <= '0;
      count <= '0;
    end else if (arm) begin
      armed <= 1'b1;
      key   <= arm_key;
      count <= CW'(REPEAT_DELAY - 1);
    end else if (disarm) begin
      armed <= 1'b0;
      key   <= '0;
      count <= '0;
    end else if (armed) begin
      if (count == '0)
        count <= CW'(REPEAT_PERIOD - 1);
      else
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/key_event_ctrl.sv
// PS/2 set-2 parser feeding a held-key vector and a single-entry
// valid/ready event register with press and auto-repeat events.
module key_event_ctrl
  import key_pkg::*;
#(
  parameter int                  REPEAT_DELAY   = 32_500_000,
  parameter int                  REPEAT_PERIOD  = 6_500_000,
  parameter int                  PREFIX_TIMEOUT = 65_000,
  parameter logic [NUM_KEYS-1:0] REPEAT_MASK    = 6'b001111
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          code,
  input  logic                code_valid,
  output logic [NUM_KEYS-1:0] held,
  output logic                event_valid,
  output logic [NUM_KEYS-1:0] event_key,
  output logic                event_repeat,
  input  logic                event_ready,
  output logic                event_drop
);

  localparam int PW = $clog2(PREFIX_TIMEOUT) + 1;

  logic [1:0]          state, next_state;
  logic [PW-1:0]       prefix_cnt;
  logic                make_byte, break_byte;
  logic [NUM_KEYS-1:0] key_oh;
  logic                press, release_key, arm, disarm;
  logic                rep_armed, rep_expire;
  logic [NUM_KEYS-1:0] rep_key;
  logic                new_valid, can_load;
  logic [NUM_KEYS-1:0] new_key;
  logic                new_repeat;
  logic                timed_out;

  assign key_oh    = decode_key(code);
  assign timed_out = (state != ST_IDLE) && (prefix_cnt == PW'(PREFIX_TIMEOUT - 1));

  always_comb begin
    next_state = state;
    make_byte  = 1'b0;
    break_byte = 1'b0;
    if (code_valid) begin
      case (state)
        ST_IDLE: begin
          if (code == CODE_E0)      next_state = ST_EXT;
          else if (code == CODE_F0) next_state = ST_BRK;
          else                      make_byte  = 1'b1;
        end
        ST_EXT: begin
          if (code == CODE_F0)      next_state = ST_EXT_BRK;
          else if (code == CODE_E0) next_state = ST_EXT;
          else begin
            make_byte  = 1'b1;
            next_state = ST_IDLE;
          end
        end
        default: begin
          if (code != CODE_F0 && code != CODE_E0) begin
            break_byte = 1'b1;
            next_state = ST_IDLE;
          end
        end
      endcase
    end else if (timed_out) begin
      next_state = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      prefix_cnt <= '0;
    end else begin
      state <= next_state;
      if (code_valid || state == ST_IDLE || timed_out)
        prefix_cnt <= '0;
      else
        prefix_cnt <= prefix_cnt + 1'b1;
    end
  end

  // Typematic makes on an already-held key produce nothing.
  assign press       = make_byte && (key_oh != '0) && ((held & key_oh) == '0);
  assign release_key = break_byte && (key_oh != '0);
  assign arm         = press && ((key_oh & REPEAT_MASK) != '0);
  assign disarm      = release_key && rep_armed && (key_oh == rep_key);

  key_repeat_timer #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_repeat (
    .clk    (clk),
    .rst    (rst),
    .arm    (arm),
    .disarm (disarm),
    .arm_key(key_oh),
    .armed  (rep_armed),
    .key    (rep_key),
    .expire (rep_expire)
  );

  always_ff @(posedge clk) begin
    if (rst)
      held <= '0;
    else if (press)
      held <= held | key_oh;
    else if (release_key)
      held <= held & ~key_oh;
  end

  // A code event wins over a same-cycle repeat; the losing repeat is silent.
  assign new_valid  = press || rep_expire;
  assign new_key    = press ? key_oh : rep_key;
  assign new_repeat = !press;
  assign can_load   = !event_valid || event_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      event_valid  <= 1'b0;
      event_key    <= '0;
      event_repeat <= 1'b0;
      event_drop   <= 1'b0;
    end else begin
      event_drop <= 1'b0;
      if (new_valid && can_load) begin
        event_valid  <= 1'b1;
        event_key    <= new_key;
        event_repeat <= new_repeat;
      end else begin
        if (new_valid)
          event_drop <= 1'b1;
        if (event_valid && event_ready)
          event_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/key_event_ctrl.md
# key_event_ctrl

Sequencer between the PS/2 byte receiver and the game FSM. It parses the raw PS/2 set-2 byte stream (E0 extended prefix, F0 break prefix) and maintains a held-state vector for the six game keys. It emits exactly one press event per physical press, plus controlled auto-repeat events, through a single-entry valid/ready event register. It replaces ad-hoc "current keycode" sampling, so menus and the race loop see clean edge events.

## Interface
- REPEAT_DELAY, 32_500_000: cycles from a press event to the first repeat event.
- REPEAT_PERIOD, 6_500_000: cycles between subsequent repeat events.
- PREFIX_TIMEOUT, 65_000: cycles after an E0/F0 prefix byte before the parser abandons it and returns to IDLE.
- REPEAT_MASK, 6'b001111: one-hot mask of keys allowed to auto-repeat (arrows repeat; Enter and Esc do not).
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- code  in  8  received scan-code byte.
- code_valid  in  1  one-cycle strobe marking `code` valid.
- held  out  6  one-hot-per-bit held state: bit0 up, bit1 down, bit2 left, bit3 right, bit4 enter, bit5 esc.
- event_valid  out  1  event register is full.
- event_key  out  6  one-hot key of the pending event.
- event_repeat  out  1  1 means auto-repeat event; 0 means a real press.
- event_ready  in  1  consumer accepts the event when event_valid && event_ready.
- event_drop  out  1  one-cycle pulse when an event is discarded because the register is full.

## Operation
- Parser FSM states: IDLE, EXT, BRK, EXT_BRK. Transitions occur only on code_valid.
  - IDLE: E0 goes to EXT, F0 goes to BRK, any other byte is a make code; stay in IDLE.
  - EXT: F0 goes to EXT_BRK, E0 stays in EXT, any other byte is a make code; go to IDLE.
  - BRK and EXT_BRK: F0 or E0 stays in the current state, any other byte is a break code; go to IDLE.
- Key map: 75 is up, 72 is down, 6B is left, 74 is right, 5A is enter, 76 is esc.
  - Accepted with or without E0, so numpad and keypad Enter also work.
  - Unmapped bytes (AA, E1, FA, etc.) only advance the FSM and have no other effect.
- Make on a key whose held bit is 0: set the held bit, post a press event (event_repeat=0), and arm repeat for that key if it is in REPEAT_MASK.
- Make on a key already held (keyboard typematic): no event, no held change.
- Break: clear the held bit. If it is the armed repeat key, disarm repeat.
- Repeat engine tracks only the most recently pressed, still-held, repeatable key.
  - A new repeatable press re-arms the engine to the new key.
  - A non-repeatable press leaves the current arming untouched.
- Repeat counter loads REPEAT_DELAY-1 on arm and decrements while armed.
  - At 0, post a repeat event (event_repeat=1) and reload REPEAT_PERIOD-1.
- Event register, when empty or being accepted in the same cycle: loads the new event.
  - Back-to-back events with event_ready high stream at one per cycle.
- Event register, when full and not accepted: the new event is discarded and event_drop pulses; the existing event is held stable.
- Simultaneous code-derived event and repeat expiry: the code event is posted, the repeat event is discarded (no event_drop), and the counter still reloads.
- Prefix timeout: a counter runs while in EXT, BRK or EXT_BRK. When it reaches PREFIX_TIMEOUT cycles with no code_valid, the FSM returns to IDLE; held is unchanged.

## Timing
- Reset values: held=0, event_valid=0, event_key=0, event_repeat=0, event_drop=0, FSM=IDLE, repeat disarmed, all counters 0.
- Final byte on code_valid at cycle N: held and event_valid updated at N+1.
- Press event visible at N+1: first repeat event at N+1+REPEAT_DELAY, then every REPEAT_PERIOD cycles, provided the register drains.
- Acceptance in cycle M: event_valid falls at M+1 unless a new event loads.
- Reset asserted mid-sequence (e.g. after E0 F0) clears everything. The next byte is parsed from IDLE.
- All outputs are registered.

## Structure
- Package key_pkg holds:
  - scan-code constants (E0, F0, and the six make codes);
  - one-hot key constants and the key index order;
  - the parser state enum.
- Sub-module key_repeat_timer: arm, disarm, key-id load, down-counter, expiry pulse. It is parameterised by REPEAT_DELAY and REPEAT_PERIOD.
- Parser, held vector and event register live in the top level.

## Test plan
- Byte 75 -> held=000001 and one event (key=000001, repeat=0). Then F0 75 -> held=000000 and no event.
- Bytes E0 6B, E0 6B, E0 6B (typematic) -> exactly one press event for left. E0 F0 6B -> held bit2 clears.
- Right held with REPEAT_DELAY=20, REPEAT_PERIOD=5 -> repeat events at +20, +25, +30 cycles after the press event. Release -> no further events.
- event_ready=0 and presses of 75 then 5A -> event_key stays 000001, event_drop pulses once. Enter held bit still sets.
- Byte F0, then PREFIX_TIMEOUT idle cycles, then 74 -> treated as a make: held bit3=1, press event.
- Byte E0 F0 then rst for 1 cycle, then 72 -> all outputs reset, then down press event and held=000010.
